// File: rtl/hdmi_audio_pkg.sv
// Shared definitions for the HDMI audio feeder path.
//   feeder_state_e : priming state machine encoding (PRIME = silence, RUN = draining)
//   AUDIO_SAMPLE_W : width of one PCM channel sample
//   UNDERRUN_CNT_W : width of the saturating underrun event counter
package hdmi_audio_pkg;

   typedef enum logic {
      FEEDER_PRIME = 1'b0,
      FEEDER_RUN   = 1'b1
   } feeder_state_e;

   localparam int AUDIO_SAMPLE_W = 16;
   localparam int UNDERRUN_CNT_W = 8;

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port storage for the audio FIFO: synchronous write, registered read.
// Written without reset or bypass so it maps onto distributed or block RAM.
//   clk     : clock
//   wr_en   : write wr_data at wr_addr on this edge
//   wr_addr : write address
//   wr_data : write data ({left, right})
//   rd_en   : load rd_data from rd_addr on this edge, otherwise hold
//   rd_addr : read address
//   rd_data : registered read data (old contents on a same-address write)
module audio_fifo_ram #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/hdmi_audio_feeder.sv
// Audio feeder in front of hdmi_interface. Buffers stereo PCM pairs from a
// valid/ready producer and hands one pair per audio_sample_strobe to the consumer.
// A two-state machine plays silence until PRIME_LEVEL entries are buffered and
// falls back to priming (counting the event) whenever a strobe finds it empty.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : producer handshake, in_left/in_right the stereo pair
//   audio_sample_strobe : consumer takes the current pair, advance to the next
//   audio_sample_left/right : current pair (0 while silent)
//   fill_level          : entries stored
//   running             : state is RUN
//   underrun_count      : saturating count of underrun events
module hdmi_audio_feeder
   import hdmi_audio_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [AUDIO_SAMPLE_W-1:0] in_left,
   input  logic signed [AUDIO_SAMPLE_W-1:0] in_right,
   input  logic                             audio_sample_strobe,
   output logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_left,
   output logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_right,
   output logic        [DEPTH_LOG2:0]       fill_level,
   output logic                             running,
   output logic        [UNDERRUN_CNT_W-1:0] underrun_count
);

   localparam int                    DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   PRIME_LVL  = (DEPTH_LOG2+1)'(PRIME_LEVEL);
   localparam logic [DEPTH_LOG2:0]   FILL_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX = '1;

   feeder_state_e               state_q, state_d;
   logic [DEPTH_LOG2-1:0]       wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]       rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]         fill_q, fill_d;
   logic                        silence_q, silence_d;
   logic [UNDERRUN_CNT_W-1:0]   underrun_q, underrun_d;

   logic                        push;
   logic                        pop;
   logic                        strobe_run;
   logic                        underrun;
   logic [2*AUDIO_SAMPLE_W-1:0] ram_rd_data;

   // Handshake and FIFO events, all from registered state
   always_comb begin
      in_ready   = (fill_q != FULL_LEVEL);
      push       = in_valid && in_ready;
      strobe_run = audio_sample_strobe && (state_q == FEEDER_RUN);
      pop        = strobe_run && (fill_q != '0);
      underrun   = strobe_run && (fill_q == '0);
   end

   // Pointers and fill counter
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FILL_ONE;
         2'b01:   fill_d = fill_q - FILL_ONE;
         default: fill_d = fill_q;
      endcase
   end

   // Priming state machine. The output pair lives in the RAM read register;
   // silence_q masks it to zero after reset, on PRIME strobes and on underruns,
   // and a pop clears it as the fresh head entry is loaded.
   always_comb begin
      state_d    = state_q;
      silence_d  = silence_q;
      underrun_d = underrun_q;
      case (state_q)
         FEEDER_PRIME: begin
            if (audio_sample_strobe) begin
               silence_d = 1'b1;
            end
            if (fill_q >= PRIME_LVL) begin
               state_d = FEEDER_RUN;
            end
         end
         FEEDER_RUN: begin
            if (pop) begin
               silence_d = 1'b0;
            end else if (underrun) begin
               silence_d = 1'b1;
               state_d   = FEEDER_PRIME;
               if (underrun_q != CNT_MAX) begin
                  underrun_d = underrun_q + 1'b1;
               end
            end
         end
         default: state_d = FEEDER_PRIME;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FEEDER_PRIME;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         silence_q  <= 1'b1;
         underrun_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         silence_q  <= silence_d;
         underrun_q <= underrun_d;
      end
   end

   audio_fifo_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (2*AUDIO_SAMPLE_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_data ({in_left, in_right}),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q),
      .rd_data (ram_rd_data)
   );

   always_comb begin
      audio_sample_left  = silence_q ? '0 : $signed(ram_rd_data[2*AUDIO_SAMPLE_W-1:AUDIO_SAMPLE_W]);
      audio_sample_right = silence_q ? '0 : $signed(ram_rd_data[AUDIO_SAMPLE_W-1:0]);
      fill_level         = fill_q;
      running            = (state_q == FEEDER_RUN);
      underrun_count     = underrun_q;
   end

endmodule
